// File: rtl/layer_pkg.sv
// Shared types and constants for the neuron layer collector: FSM states,
// accumulator width derivation and the sign-activation convention.
package layer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    SCAN  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int unsigned ACC_MULT = 4;

  // Activation bit produced for an accumulator value of exactly zero.
  localparam logic ACT_ZERO = 1'b1;

  function automatic int unsigned acc_width(input int unsigned width);
    return ACC_MULT * width;
  endfunction

endpackage

// File: rtl/signed_max_step.sv
// One step of a running signed argmax: takes the candidate on the first step
// or when strictly greater, so ties keep the lowest index.
module signed_max_step #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned IDX_W = 4
) (
  input  logic                    first,
  input  logic signed [ACC_W-1:0] cand,
  input  logic        [IDX_W-1:0] cand_idx,
  input  logic signed [ACC_W-1:0] cur_max,
  input  logic        [IDX_W-1:0] cur_idx,
  output logic signed [ACC_W-1:0] next_max_c,
  output logic        [IDX_W-1:0] next_idx_c
);

  always_comb begin
    next_max_c = cur_max;
    next_idx_c = cur_idx;
    if (first || (cand > cur_max)) begin
      next_max_c = cand;
      next_idx_c = cand_idx;
    end
  end

endmodule

// File: rtl/neuron_layer_collector.sv
// Drives a neuron bank through clear/run, snapshots its accumulators once all
// are done, then scans them into sign activations plus an argmax result.
module neuron_layer_collector
  import layer_pkg::*;
#(
  parameter  int unsigned N_NEURONS = 10,
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned IDX_W     = $clog2(N_NEURONS),
  localparam int unsigned ACC_W     = acc_width(WIDTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [N_NEURONS*ACC_W-1:0] neuron_out,
  input  logic [N_NEURONS-1:0]       neuron_done,
  output logic                       neuron_en,
  output logic                       neuron_reset,
  output logic [N_NEURONS-1:0]       act_bits,
  output logic [IDX_W-1:0]           class_idx,
  output logic signed [ACC_W-1:0]    class_score,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  state_t                  state;
  logic signed [ACC_W-1:0] snap [N_NEURONS];
  logic [IDX_W-1:0]        k;
  logic signed [ACC_W-1:0] work_max;
  logic [IDX_W-1:0]        work_idx;
  logic [N_NEURONS-1:0]    work_act;

  logic signed [ACC_W-1:0] cand_c;
  logic signed [ACC_W-1:0] step_max_c;
  logic [IDX_W-1:0]        step_idx_c;
  logic [N_NEURONS-1:0]    act_next_c;
  logic                    last_c;

  // Scan datapath: current snapshot entry folded into the working results.
  always_comb begin
    cand_c        = snap[k];
    act_next_c    = work_act;
    act_next_c[k] = (cand_c == '0) ? ACT_ZERO : ~cand_c[ACC_W-1];
    last_c        = (k == IDX_W'(N_NEURONS - 1));
  end

  signed_max_step #(
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_max_step (
    .first      (k == '0),
    .cand       (cand_c),
    .cand_idx   (k),
    .cur_max    (work_max),
    .cur_idx    (work_idx),
    .next_max_c (step_max_c),
    .next_idx_c (step_idx_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      neuron_en    <= 1'b0;
      neuron_reset <= 1'b0;
      act_bits     <= '0;
      class_idx    <= '0;
      class_score  <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      k            <= '0;
      work_max     <= '0;
      work_idx     <= '0;
      work_act     <= '0;
      for (int unsigned i = 0; i < N_NEURONS; i++) snap[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= CLEAR;
            neuron_reset <= 1'b1;
            busy         <= 1'b1;
          end
        end
        CLEAR: begin
          state        <= RUN;
          neuron_reset <= 1'b0;
          neuron_en    <= 1'b1;
        end
        RUN: begin
          if (&neuron_done) begin
            for (int unsigned i = 0; i < N_NEURONS; i++)
              snap[i] <= neuron_out[i*ACC_W +: ACC_W];
            neuron_en <= 1'b0;
            k         <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          work_max <= step_max_c;
          work_idx <= step_idx_c;
          work_act <= act_next_c;
          if (last_c) begin
            act_bits    <= act_next_c;
            class_idx   <= step_idx_c;
            class_score <= step_max_c;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else begin
            k <= k + IDX_W'(1);
          end
        end
        HOLD: begin
          // Result registers persist past the handshake; only valid drops.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state        <= CLEAR;
              neuron_reset <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          neuron_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_collector.sv
// Bench for neuron_layer_collector: behavioural neuron bank plus argmax/sign
// reference model, directed corner cases followed by randomized evaluations.
module tb_neuron_layer_collector;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned IDX_W = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    start = 1'b0;
  logic                    out_ready = 1'b0;
  logic [N*ACC_W-1:0]      neuron_out;
  logic [N-1:0]            neuron_done;
  logic                    neuron_en;
  logic                    neuron_reset;
  logic [N-1:0]            act_bits;
  logic [IDX_W-1:0]        class_idx;
  logic signed [ACC_W-1:0] class_score;
  logic                    out_valid;
  logic                    busy;

  int vals [N];
  int dly  [N];
  int cnt  [N];

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [N-1:0] exp_act;
  int           exp_idx;
  int           exp_score;

  always #5 clk = ~clk;

  neuron_layer_collector #(
    .N_NEURONS (N),
    .WIDTH     (WIDTH),
    .IDX_W     (IDX_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .neuron_out   (neuron_out),
    .neuron_done  (neuron_done),
    .neuron_en    (neuron_en),
    .neuron_reset (neuron_reset),
    .act_bits     (act_bits),
    .class_idx    (class_idx),
    .class_score  (class_score),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  // Neuron bank: each neuron counts enabled cycles and is done after dly[i].
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (neuron_reset)   cnt[i] <= 0;
      else if (neuron_en) cnt[i] <= cnt[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      neuron_out[i*ACC_W +: ACC_W] = vals[i];
      neuron_done[i]               = (cnt[i] >= dly[i]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: sign activation and first-occurrence maximum over vals.
  task automatic compute_expected();
    exp_idx   = 0;
    exp_score = vals[0];
    for (int i = 0; i < N; i++) begin
      exp_act[i] = (vals[i] >= 0);
      if (vals[i] > exp_score) begin
        exp_score = vals[i];
        exp_idx   = i;
      end
    end
  endtask

  task automatic load(input int v0, input int v1, input int v2, input int v3,
                      input int d0, input int d1, input int d2, input int d3);
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    dly[0]  = d0; dly[1]  = d1; dly[2]  = d2; dly[3]  = d3;
  endtask

  function automatic int rand_val();
    int r;
    case ($urandom_range(0, 3))
      0:       r = int'($urandom_range(0, 20)) - 10;
      1:       r = int'(32'h8000_0000);
      default: r = int'($urandom);
    endcase
    return r;
  endfunction

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      vals[i] = rand_val();
      dly[i]  = int'($urandom_range(1, 8));
    end
  endtask

  task automatic run_eval(input bit prestarted);
    int dmax;
    int lat;
    compute_expected();
    dmax = 0;
    for (int i = 0; i < N; i++) if (dly[i] > dmax) dmax = dly[i];
    if (!prestarted) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("clear_pulse", 64'(neuron_reset), 64'(1));
    chk("clear_en_low", 64'(neuron_en), 64'(0));
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == dmax + 1) chk("en_until_all_done", 64'(neuron_en), 64'(1));
      if (lat == dmax + 2) begin
        chk("en_drop_after_snap", 64'(neuron_en), 64'(0));
        for (int i = 0; i < N; i++) vals[i] = int'($urandom);
      end
    end
    if (!out_valid) begin
      chk("timeout_out_valid", 64'(0), 64'(1));
      return;
    end
    chk("latency", 64'(lat), 64'(1 + dmax + 1 + N));
    chk("act_bits", 64'(act_bits), 64'(exp_act));
    chk("class_idx", 64'(class_idx), 64'(exp_idx));
    chk("class_score", 64'(class_score), 64'(exp_score));
    chk("busy_hold", 64'(busy), 64'(1));
  endtask

  task automatic handshake(input bit with_start);
    out_ready = 1'b1;
    start     = with_start;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    chk("valid_cleared", 64'(out_valid), 64'(0));
    chk("b2b_clear", 64'(neuron_reset), 64'(with_start));
    chk("busy_after_ack", 64'(busy), 64'(with_start));
    chk("act_kept", 64'(act_bits), 64'(exp_act));
    chk("idx_kept", 64'(class_idx), 64'(exp_idx));
    chk("score_kept", 64'(class_score), 64'(exp_score));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_en"}, 64'(neuron_en), 64'(0));
    chk({tag, "_nrst"}, 64'(neuron_reset), 64'(0));
    chk({tag, "_act"}, 64'(act_bits), 64'(0));
    chk({tag, "_idx"}, 64'(class_idx), 64'(0));
    chk({tag, "_score"}, 64'(class_score), 64'(0));
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    bit chained;
    int dmax;
    for (int i = 0; i < N; i++) begin vals[i] = 0; dly[i] = 1; end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'(0));

    // Basic evaluation and latency.
    load(5, -3, 12, 0, 3, 3, 3, 3);
    run_eval(1'b0);
    handshake(1'b0);

    // Tie resolves to lowest index.
    load(7, 7, -1, -1, 1, 2, 1, 1);
    run_eval(1'b0);
    handshake(1'b0);

    // All negative including the most negative value.
    load(-10, -2, int'(32'h8000_0000), -5, 2, 1, 3, 1);
    run_eval(1'b0);
    handshake(1'b0);

    // Staggered done flags, then backpressure with an ignored start.
    load(-7, 100, 3, 100, 2, 9, 4, 6);
    run_eval(1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(posedge clk); #1;
      start = 1'b0;
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_no_clear", 64'(neuron_reset), 64'(0));
      chk("bp_act", 64'(act_bits), 64'(exp_act));
      chk("bp_idx", 64'(class_idx), 64'(exp_idx));
      chk("bp_score", 64'(class_score), 64'(exp_score));
    end
    handshake(1'b1);
    load(-1, -1, 0, int'(32'h7FFF_FFFF), 1, 1, 1, 1);
    run_eval(1'b1);
    handshake(1'b0);

    // Asynchronous reset in the middle of SCAN.
    load(1, 2, 3, 4, 2, 2, 2, 2);
    dmax = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (dmax + 2 + 2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    load(-4, 9, 9, -8, 3, 1, 2, 4);
    run_eval(1'b0);
    handshake(1'b0);

    // Randomized evaluations, some issued back-to-back.
    chained = 1'b0;
    for (int it = 0; it < 10; it++) begin
      load_random();
      run_eval(chained);
      chained = 1'($urandom_range(0, 1));
      handshake(chained);
    end
    if (chained) begin
      load_random();
      run_eval(1'b1);
      handshake(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
